// File: rtl/sysid_regs_pkg.sv
// Shared register map, CTRL bit positions and address type for the system-ID /
// uptime slave.
package sysid_regs_pkg;

  typedef logic [2:0] reg_addr_t;

  localparam reg_addr_t ADDR_ID        = 3'd0;
  localparam reg_addr_t ADDR_TIMESTAMP = 3'd1;
  localparam reg_addr_t ADDR_VERSION   = 3'd2;
  localparam reg_addr_t ADDR_SCRATCH   = 3'd3;
  localparam reg_addr_t ADDR_CYCLE_LO  = 3'd4;
  localparam reg_addr_t ADDR_CYCLE_HI  = 3'd5;
  localparam reg_addr_t ADDR_SECONDS   = 3'd6;
  localparam reg_addr_t ADDR_CTRL      = 3'd7;

  localparam int CTRL_CLEAR  = 0;
  localparam int CTRL_FREEZE = 1;

  // CLEAR is a pulse and always reads back as 0; only FREEZE is visible.
  function automatic logic [31:0] ctrl_readback(input logic freeze);
    return {30'b0, freeze, 1'b0};
  endfunction

endpackage

// File: rtl/sysid_regs_uptime_if.sv
// Avalon-MM slave bus bundle. Handshake: read/write are one-cycle strobes with no
// waitrequest; readdatavalid pulses exactly one clock after each accepted read.
interface sysid_regs_uptime_if #(
  parameter int DATA_WIDTH = 32
);
  import sysid_regs_pkg::*;

  reg_addr_t               address;
  logic                    read;
  logic                    write;
  logic [DATA_WIDTH-1:0]   writedata;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;

  modport master (
    output address, read, write, writedata,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata, readdatavalid
  );

endinterface

// File: rtl/sysid_uptime_counter.sv
// Free-running 64-bit cycle counter plus a prescaled seconds counter.
// clear wins over freeze and increment on the same edge.
module sysid_uptime_counter #(
  parameter int CLK_FREQ_HZ = 50_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        freeze,
  output logic [63:0] cycle_cnt,
  output logic [31:0] seconds
);

  localparam int              PS_W    = (CLK_FREQ_HZ > 2) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_FREQ_HZ - 1);

  if (CLK_FREQ_HZ < 2) begin : g_bad_freq
    $error("sysid_uptime_counter: CLK_FREQ_HZ must be 2 or more");
  end

  logic [63:0]     r_cycle_cnt;
  logic [PS_W-1:0] r_prescale;
  logic [31:0]     r_seconds;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cycle_cnt <= '0;
      r_prescale  <= '0;
      r_seconds   <= '0;
    end else if (clear) begin
      r_cycle_cnt <= '0;
      r_prescale  <= '0;
      r_seconds   <= '0;
    end else if (!freeze) begin
      r_cycle_cnt <= r_cycle_cnt + 64'd1;
      if (r_prescale == PS_LAST) begin
        r_prescale <= '0;
        r_seconds  <= r_seconds + 32'd1;
      end else begin
        r_prescale <= r_prescale + 1'b1;
      end
    end
  end

  assign cycle_cnt = r_cycle_cnt;
  assign seconds   = r_seconds;

endmodule

// File: rtl/sysid_regs_uptime.sv
// System-ID slave: constant ID/timestamp/version words, scratch register, and an
// uptime block with a LO-read-triggered HI snapshot and freeze/clear control.
module sysid_regs_uptime
  import sysid_regs_pkg::*;
#(
  parameter int          DATA_WIDTH      = 32,
  parameter logic [31:0] ID_VALUE        = 32'hABCD_1289,
  parameter logic [31:0] TIMESTAMP_VALUE = 32'h56B2_7538,
  parameter logic [31:0] VERSION_VALUE   = 32'h0001_0000,
  parameter logic [31:0] SCRATCH_RESET   = 32'h0000_0000,
  parameter int          CLK_FREQ_HZ     = 50_000_000
) (
  input  logic               clock,
  input  logic               reset,
  sysid_regs_uptime_if.slave bus
);

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("sysid_regs_uptime: DATA_WIDTH must be 32");
  end

  logic [31:0] r_scratch;
  logic [31:0] r_hi_shadow;
  logic        r_freeze;
  logic [31:0] r_readdata;
  logic        r_readdatavalid;

  logic        w_wr_en;
  logic        w_ctrl_wr;
  logic        w_clear;
  logic [63:0] w_cycle_cnt;
  logic [31:0] w_seconds;
  logic [31:0] w_rd_mux;

  // A write colliding with a read is dropped; the read is serviced.
  assign w_wr_en   = bus.write && !bus.read;
  assign w_ctrl_wr = w_wr_en && (bus.address == ADDR_CTRL);
  assign w_clear   = w_ctrl_wr && bus.writedata[CTRL_CLEAR];

  sysid_uptime_counter #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ)
  ) u_cnt (
    .clock     (clock),
    .reset     (reset),
    .clear     (w_clear),
    .freeze    (r_freeze),
    .cycle_cnt (w_cycle_cnt),
    .seconds   (w_seconds)
  );

  always_comb begin
    w_rd_mux = '0;
    case (bus.address)
      ADDR_ID:        w_rd_mux = ID_VALUE;
      ADDR_TIMESTAMP: w_rd_mux = TIMESTAMP_VALUE;
      ADDR_VERSION:   w_rd_mux = VERSION_VALUE;
      ADDR_SCRATCH:   w_rd_mux = r_scratch;
      ADDR_CYCLE_LO:  w_rd_mux = w_cycle_cnt[31:0];
      ADDR_CYCLE_HI:  w_rd_mux = r_hi_shadow;
      ADDR_SECONDS:   w_rd_mux = w_seconds;
      ADDR_CTRL:      w_rd_mux = ctrl_readback(r_freeze);
      default:        w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_scratch       <= SCRATCH_RESET;
      r_hi_shadow     <= '0;
      r_freeze        <= 1'b0;
      r_readdata      <= '0;
      r_readdatavalid <= 1'b0;
    end else begin
      r_readdatavalid <= bus.read;
      if (bus.read) begin
        r_readdata <= w_rd_mux;
      end
      // HI is captured on the same edge as LO so a LO-then-HI pair is coherent.
      if (bus.read && (bus.address == ADDR_CYCLE_LO)) begin
        r_hi_shadow <= w_cycle_cnt[63:32];
      end
      if (w_wr_en && (bus.address == ADDR_SCRATCH)) begin
        r_scratch <= bus.writedata;
      end
      if (w_ctrl_wr) begin
        r_freeze <= bus.writedata[CTRL_FREEZE];
      end
    end
  end

  assign bus.readdata      = r_readdata;
  assign bus.readdatavalid = r_readdatavalid;

  a_no_read_write: assert property (
    @(posedge clock) disable iff (reset) !(bus.read && bus.write)
  );

endmodule

// File: tb/tb_sysid_regs_uptime.sv
// Self-checking bench for sysid_regs_uptime with a 10-cycle seconds prescaler.
module tb_sysid_regs_uptime;
  import sysid_regs_pkg::*;

  localparam int          CLK_HZ  = 10;
  localparam logic [31:0] ID_W    = 32'hABCD_1289;
  localparam logic [31:0] TS_W    = 32'h56B2_7538;
  localparam logic [31:0] VER_W   = 32'h0001_0000;
  localparam logic [31:0] SCR_RST = 32'h0000_0000;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  sysid_regs_uptime_if bus ();

  sysid_regs_uptime #(
    .DATA_WIDTH      (32),
    .ID_VALUE        (ID_W),
    .TIMESTAMP_VALUE (TS_W),
    .VERSION_VALUE   (VER_W),
    .SCRATCH_RESET   (SCR_RST),
    .CLK_FREQ_HZ     (CLK_HZ)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: elapsed unfrozen cycles k since clear/reset gives seconds = k / CLK_HZ.
  function automatic logic [31:0] exp_seconds(input int k);
    return 32'(k / CLK_HZ);
  endfunction

  // Each call starts and ends on a falling edge; n rising edges pass.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    bus.read  = 1'b0;
    bus.write = 1'b0;
    rst       = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic bus_read(input reg_addr_t a, output logic [31:0] d, output logic v);
    bus.address = a;
    bus.read    = 1'b1;
    tick(1);
    bus.read = 1'b0;
    d = bus.readdata;
    v = bus.readdatavalid;
  endtask

  task automatic bus_write(input reg_addr_t a, input logic [31:0] d);
    bus.address   = a;
    bus.writedata = d;
    bus.write     = 1'b1;
    tick(1);
    bus.write = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        v;
    do_reset();
    n_checks++; if (bus.readdata !== 32'h0) begin n_errors++; $display("FAIL reset_readdata got %h exp %h", bus.readdata, 32'h0); end
    n_checks++; if (bus.readdatavalid !== 1'b0) begin n_errors++; $display("FAIL reset_rdv got %b exp 0", bus.readdatavalid); end
    bus_read(ADDR_CTRL, d, v);
    n_checks++; if (d !== 32'h0) begin n_errors++; $display("FAIL reset_ctrl got %h exp %h", d, 32'h0); end
    bus_read(ADDR_SCRATCH, d, v);
    n_checks++; if (d !== SCR_RST) begin n_errors++; $display("FAIL reset_scratch got %h exp %h", d, SCR_RST); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w [3];
    exp_w[0] = ID_W; exp_w[1] = TS_W; exp_w[2] = VER_W;
    do_reset();
    bus.read = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.address = reg_addr_t'(i);
      tick(1);
      if (i == 2) bus.read = 1'b0;
      n_checks++; if (bus.readdatavalid !== 1'b1) begin n_errors++; $display("FAIL b2b_rdv[%0d] got %b exp 1", i, bus.readdatavalid); end
      n_checks++; if (bus.readdata !== exp_w[i]) begin n_errors++; $display("FAIL b2b_data[%0d] got %h exp %h", i, bus.readdata, exp_w[i]); end
    end
    tick(1);
    n_checks++; if (bus.readdatavalid !== 1'b0) begin n_errors++; $display("FAIL b2b_rdv_drop got %b exp 0", bus.readdatavalid); end
    n_checks++; if (bus.readdata !== VER_W) begin n_errors++; $display("FAIL b2b_hold got %h exp %h", bus.readdata, VER_W); end
  endtask

  task automatic test_scratch();
    logic [31:0] d;
    logic [31:0] w;
    logic        v;
    do_reset();
    bus_write(ADDR_SCRATCH, 32'hDEAD_BEEF);
    bus_read(ADDR_SCRATCH, d, v);
    n_checks++; if (d !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL scratch_rw got %h exp %h", d, 32'hDEAD_BEEF); end
    do_reset();
    bus_read(ADDR_SCRATCH, d, v);
    n_checks++; if (d !== SCR_RST) begin n_errors++; $display("FAIL scratch_after_reset got %h exp %h", d, SCR_RST); end
    for (int i = 0; i < 4; i++) begin
      w = $urandom;
      bus_write(ADDR_SCRATCH, w);
      tick($urandom_range(0, 3));
      bus_read(ADDR_SCRATCH, d, v);
      n_checks++; if (d !== w) begin n_errors++; $display("FAIL scratch_rand[%0d] got %h exp %h", i, d, w); end
    end
    bus_write(ADDR_ID, $urandom);
    bus_write(ADDR_VERSION, $urandom);
    bus_read(ADDR_ID, d, v);
    n_checks++; if (d !== ID_W) begin n_errors++; $display("FAIL ro_id_write got %h exp %h", d, ID_W); end
    bus_read(ADDR_VERSION, d, v);
    n_checks++; if (d !== VER_W) begin n_errors++; $display("FAIL ro_ver_write got %h exp %h", d, VER_W); end
  endtask

  task automatic test_seconds();
    logic [31:0] d;
    logic        v;
    int          k;
    do_reset();
    tick(29);
    bus_read(ADDR_SECONDS, d, v);
    n_checks++; if (d !== exp_seconds(29)) begin n_errors++; $display("FAIL sec_before_wrap got %h exp %h", d, exp_seconds(29)); end
    bus_read(ADDR_SECONDS, d, v);
    n_checks++; if (d !== exp_seconds(30)) begin n_errors++; $display("FAIL sec_at_wrap got %h exp %h", d, exp_seconds(30)); end
    tick(4);
    bus_read(ADDR_SECONDS, d, v);
    n_checks++; if (d !== 32'd3) begin n_errors++; $display("FAIL sec_35 got %h exp %h", d, 32'd3); end
    for (int i = 0; i < 4; i++) begin
      do_reset();
      k = $urandom_range(1, 60);
      tick(k);
      bus_read(ADDR_CYCLE_LO, d, v);
      n_checks++; if (d !== 32'(k)) begin n_errors++; $display("FAIL cyc_lo_rand[%0d] got %h exp %h", i, d, 32'(k)); end
      bus_read(ADDR_SECONDS, d, v);
      n_checks++; if (d !== exp_seconds(k + 1)) begin n_errors++; $display("FAIL sec_rand[%0d] got %h exp %h", i, d, exp_seconds(k + 1)); end
      bus_read(ADDR_CYCLE_HI, d, v);
      n_checks++; if (d !== 32'h0) begin n_errors++; $display("FAIL cyc_hi_rand[%0d] got %h exp %h", i, d, 32'h0); end
    end
  endtask

  task automatic test_snapshot();
    logic [31:0] d;
    logic        v;
    do_reset();
    force dut.u_cnt.r_cycle_cnt = 64'h0000_0000_FFFF_FFFF;
    release dut.u_cnt.r_cycle_cnt;
    tick(1);
    bus_read(ADDR_CYCLE_LO, d, v);
    n_checks++; if (d !== 32'h0) begin n_errors++; $display("FAIL snap_lo got %h exp %h", d, 32'h0); end
    tick(5);
    bus_read(ADDR_CYCLE_HI, d, v);
    n_checks++; if (d !== 32'h1) begin n_errors++; $display("FAIL snap_hi got %h exp %h", d, 32'h1); end
    bus_read(ADDR_CYCLE_LO, d, v);
    n_checks++; if (d !== 32'd7) begin n_errors++; $display("FAIL snap_lo_later got %h exp %h", d, 32'd7); end
  endtask

  task automatic test_freeze_clear();
    logic [31:0] d;
    logic [31:0] first;
    logic        v;
    int          k;
    do_reset();
    k = $urandom_range(5, 20);
    tick(k);
    bus_write(ADDR_CTRL, 32'h2);
    bus_read(ADDR_CYCLE_LO, first, v);
    n_checks++; if (first !== 32'(k + 1)) begin n_errors++; $display("FAIL frz_lo1 got %h exp %h", first, 32'(k + 1)); end
    tick(20);
    bus_read(ADDR_CYCLE_LO, d, v);
    n_checks++; if (d !== 32'(k + 1)) begin n_errors++; $display("FAIL frz_lo2 got %h exp %h", d, 32'(k + 1)); end
    bus_read(ADDR_SECONDS, d, v);
    n_checks++; if (d !== exp_seconds(k + 1)) begin n_errors++; $display("FAIL frz_sec got %h exp %h", d, exp_seconds(k + 1)); end
    bus_read(ADDR_CTRL, d, v);
    n_checks++; if (d !== 32'h2) begin n_errors++; $display("FAIL frz_ctrl got %h exp %h", d, 32'h2); end
    bus_write(ADDR_CTRL, 32'h1);
    tick(1);
    bus_read(ADDR_CYCLE_LO, d, v);
    n_checks++; if (d !== 32'h1) begin n_errors++; $display("FAIL clr_lo got %h exp %h", d, 32'h1); end
    bus_read(ADDR_SECONDS, d, v);
    n_checks++; if (d !== 32'h0) begin n_errors++; $display("FAIL clr_sec got %h exp %h", d, 32'h0); end
    bus_read(ADDR_CTRL, d, v);
    n_checks++; if (d !== 32'h0) begin n_errors++; $display("FAIL clr_ctrl got %h exp %h", d, 32'h0); end
    bus_write(ADDR_CTRL, 32'h3);
    tick(5);
    bus_read(ADDR_CYCLE_LO, d, v);
    n_checks++; if (d !== 32'h0) begin n_errors++; $display("FAIL clrfrz_lo got %h exp %h", d, 32'h0); end
    bus_write(ADDR_CTRL, 32'hFFFF_FFFE);
    bus_read(ADDR_CTRL, d, v);
    n_checks++; if (d !== 32'h2) begin n_errors++; $display("FAIL ctrl_mask got %h exp %h", d, 32'h2); end
    bus_write(ADDR_CTRL, 32'h0);
    bus_read(ADDR_CYCLE_LO, d, v);
    n_checks++; if (d !== 32'h0) begin n_errors++; $display("FAIL unfrz_lo0 got %h exp %h", d, 32'h0); end
    bus_read(ADDR_CYCLE_LO, d, v);
    n_checks++; if (d !== 32'h1) begin n_errors++; $display("FAIL unfrz_lo1 got %h exp %h", d, 32'h1); end
    // Freeze just before a seconds boundary must also hold the prescaler.
    do_reset();
    tick(8);
    bus_write(ADDR_CTRL, 32'h2);
    tick(10);
    bus_write(ADDR_CTRL, 32'h0);
    bus_read(ADDR_SECONDS, d, v);
    n_checks++; if (d !== exp_seconds(9)) begin n_errors++; $display("FAIL frz_ps_hold got %h exp %h", d, exp_seconds(9)); end
    bus_read(ADDR_SECONDS, d, v);
    n_checks++; if (d !== exp_seconds(10)) begin n_errors++; $display("FAIL frz_ps_resume got %h exp %h", d, exp_seconds(10)); end
  endtask

  task automatic test_reset_inflight();
    do_reset();
    tick(3);
    bus.address = ADDR_ID;
    bus.read    = 1'b1;
    @(posedge clk);
    #1;
    bus.read = 1'b0;
    rst      = 1'b1;
    #1;
    n_checks++; if (bus.readdatavalid !== 1'b0) begin n_errors++; $display("FAIL inflight_rdv got %b exp 0", bus.readdatavalid); end
    n_checks++; if (bus.readdata !== 32'h0) begin n_errors++; $display("FAIL inflight_data got %h exp %h", bus.readdata, 32'h0); end
    tick(1);
    n_checks++; if (bus.readdatavalid !== 1'b0) begin n_errors++; $display("FAIL inflight_rdv_hold got %b exp 0", bus.readdatavalid); end
    rst = 1'b0;
    tick(1);
    n_checks++; if (bus.readdatavalid !== 1'b0) begin n_errors++; $display("FAIL inflight_rdv_after got %b exp 0", bus.readdatavalid); end
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    bus.address   = ADDR_ID;
    bus.read      = 1'b0;
    bus.write     = 1'b0;
    bus.writedata = 32'h0;
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_scratch();
    test_seconds();
    test_snapshot();
    test_freeze_clear();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
